serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised multi-cycle successor of the single-bit full subtractor.
- Subtracts two WIDTH-bit operands with a borrow-in, DIGIT bits per clock.
- Each bit slice uses the full-subtractor equations: diff = a^b^c, borrow = (~a&b)|(~a&c)|(b&c).
- Used where area matters more than latency; start/busy/done handshake to the controlling datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 1.
- DIGIT, 1, bits processed per clock; WIDTH must be an integer multiple of DIGIT. N = WIDTH/DIGIT is the number of processing cycles.

Ports:
- clk      input   1      rising-edge clock
- rst      input   1      synchronous, active-high reset
- start    input   1      request; sampled only in IDLE
- a        input   WIDTH  minuend, captured on accepted start
- b        input   WIDTH  subtrahend, captured on accepted start
- bin      input   1      borrow-in to bit 0, captured on accepted start
- busy     output  1      high while an operation is in progress
- done     output  1      one-cycle pulse; diff/bout valid and updated
- diff     output  WIDTH  a - b - bin, modulo 2^WIDTH; held until next completion
- bout     output  1      borrow out of the MSB; held with diff
- ovf      output  1      signed overflow flag (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; counter and internal shift registers cleared.
- Reset has priority over all other inputs.
- Reset mid-operation aborts the operation: no done pulse; outputs take their reset values.
- State machine:
  - IDLE: when start=1 at edge E, capture a, b, bin into internal registers, clear digit counter, go to RUN; busy=1 from edge E onward. If start=0, stay in IDLE.
  - RUN: at each edge, process one DIGIT-wide slice, LSB slice first. Borrow ripples inside the slice; a registered borrow carries it between slices. Slice difference bits shift into an internal result register. Counter increments.
  - At edge E+N the final slice is processed and the FSM returns to IDLE. In the same edge: diff is loaded with the full result, bout with the final borrow, ovf updated, done=1, busy=0.
  - done drops at the next edge.
- Latency: start edge to done assertion is exactly N cycles (8 for WIDTH=8, DIGIT=1; 2 for DIGIT=4).
- start while busy=1 is ignored and operands are not re-sampled.
- start=1 in the cycle done=1 (FSM already in IDLE) is accepted. Back-to-back throughput: one result per N cycles.
- diff, bout and ovf change only at completion or reset; intermediate values are never visible.
- DIGIT=WIDTH is legal: single-cycle operation, N=1.
- Counter width is clog2(N)+1; no wrap occurs within an operation.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined: at completion, ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the captured operands; held with diff.
- Not defined: no overflow logic is compiled; ovf is tied to 0. All other behaviour is identical.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x35, b=0x12, bin=0, start pulse -> done exactly 8 cycles later; diff=0x23, bout=0; busy high for 8 cycles.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
- start held high through the whole operation, operands changed mid-run -> result uses the first captured operands. A second operation starts on the done cycle and its done arrives 8 cycles later.
- rst asserted 4 cycles into an operation -> no done pulse; busy=0, diff=0, bout=0 on the next cycle; a new start afterwards completes normally.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0; ovf=1 with SERIAL_SUBTRACTOR_OVF_EN defined, ovf=0 without. a=0x05, b=0x03 -> ovf=0 in both builds.
- WIDTH=8, DIGIT=4: a=0xA7, b=0x5C -> done 2 cycles after start; diff=0x4B, bout=0. Randomised 1000 operations against the reference a-b-bin: all match.

Source files
------------

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, start/busy/done handshake.
// Define SERIAL_SUBTRACTOR_OVF_EN to compile the signed-overflow flag; otherwise ovf is tied low.
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N) + 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             borrow_q;
   logic [CW-1:0]    cnt;

   logic [DIGIT-1:0] slice_diff;
   logic             slice_borrow;
   logic [WIDTH-1:0] res_next;
   logic             last;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic a_msb;
   logic b_msb;
`endif

   // Borrow ripples through the DIGIT bits of the current slice, seeded by the registered borrow.
   always_comb begin
      logic c;
      // NOTE: blocking assignments here are deliberate; c must update bit by bit within one evaluation.
      c          = borrow_q;
      slice_diff = '0;
      for (int i = 0; i < DIGIT; i++) begin
         slice_diff[i] = a_sh[i] ^ b_sh[i] ^ c;
         c             = (~a_sh[i] & b_sh[i]) | (~a_sh[i] & c) | (b_sh[i] & c);
      end
      slice_borrow = c;
   end

   // Slices enter at the top, so after N shifts the first slice sits in the LSBs.
   assign res_next = (res_sh >> DIGIT) | (WIDTH'(slice_diff) << (WIDTH - DIGIT));
   assign last     = (cnt == CW'(N - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: every register including the operand/result shifters is reset, so an abort leaves no stale state.
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         diff     <= '0;
         bout     <= 1'b0;
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         borrow_q <= 1'b0;
         cnt      <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf      <= 1'b0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  borrow_q <= bin;
                  res_sh   <= '0;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  a_msb    <= a[WIDTH-1];
                  b_msb    <= b[WIDTH-1];
`endif
               end
            end
            RUN: begin
               a_sh     <= a_sh >> DIGIT;
               b_sh     <= b_sh >> DIGIT;
               res_sh   <= res_next;
               borrow_q <= slice_borrow;
               cnt      <= cnt + CW'(1);
               if (last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  diff  <= res_next;
                  bout  <= slice_borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  ovf   <= (a_msb != b_msb) & (res_next[WIDTH-1] != a_msb);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef SERIAL_SUBTRACTOR_OVF_EN
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and table-driven bench for serial_subtractor, exercising DIGIT=1 and DIGIT=4 builds.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start1, start4;
   logic [7:0] a, b;
   logic       bin;
   logic       busy1, done1, bout1, ovf1;
   logic       busy4, done4, bout4, ovf4;
   logic [7:0] diff1, diff4;

   int total = 0;
   int bad   = 0;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .bin(bin),
      .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
   );

   serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .bin(bin),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
   );

   logic       sel4;
   logic       cur_busy, cur_done, cur_bout, cur_ovf;
   logic [7:0] cur_diff;
   assign cur_busy = sel4 ? busy4 : busy1;
   assign cur_done = sel4 ? done4 : done1;
   assign cur_bout = sel4 ? bout4 : bout1;
   assign cur_ovf  = sel4 ? ovf4  : ovf1;
   assign cur_diff = sel4 ? diff4 : diff1;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called #1 after the accepting edge; watches for done within a bounded window.
   task automatic wait_done(output int lat, output bit seen, output bit steady);
      logic [7:0] d0;
      logic       b0;
      d0     = cur_diff;
      b0     = cur_bout;
      seen   = 1'b0;
      steady = 1'b1;
      lat    = 0;
      while (!seen && lat < 20) begin
         if (cur_busy !== 1'b1 || cur_diff !== d0 || cur_bout !== b0) steady = 1'b0;
         @(posedge clk); #1;
         lat++;
         if (cur_done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic do_op(input bit use4, input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                        input logic [7:0] ed, input logic eb, input logic eo, input string tag);
      int lat;
      bit seen, steady;
      sel4 = use4;
      a    = va;
      b    = vb;
      bin  = vbin;
      if (use4) start4 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      start4 = 1'b0;
      wait_done(lat, seen, steady);
      check({tag, "_seen"},    32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(lat), use4 ? 32'd2 : 32'd8);
      check({tag, "_steady"},  32'(steady), 32'd1);
      check({tag, "_diff"},    32'(cur_diff), 32'(ed));
      check({tag, "_bout"},    32'(cur_bout), 32'(eb));
      check({tag, "_ovf"},     32'(cur_ovf), 32'(eo & OVF_EN));
      check({tag, "_busy_end"}, 32'(cur_busy), 32'd0);
      @(posedge clk); #1;
      check({tag, "_done_drop"}, 32'(cur_done), 32'd0);
   endtask

   initial begin
      int  lat;
      bit  seen, steady;
      logic [8:0] ref9;
      logic [7:0] ra, rb;
      logic       rbin, rovf;

      vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[4] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      vecs[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[8] = '{8'hA7, 8'h5C, 1'b0, 8'h4B, 1'b0, 1'b1};

      sel4   = 1'b0;
      rst    = 1'b1;
      start1 = 1'b0;
      start4 = 1'b0;
      a      = 8'h00;
      b      = 8'h00;
      bin    = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_busy1", 32'(busy1), 32'd0);
      check("rst_done1", 32'(done1), 32'd0);
      check("rst_diff1", 32'(diff1), 32'd0);
      check("rst_bout1", 32'(bout1), 32'd0);
      check("rst_ovf1",  32'(ovf1),  32'd0);
      check("rst_busy4", 32'(busy4), 32'd0);
      check("rst_diff4", 32'(diff4), 32'd0);

      for (int i = 0; i < 9; i++) begin
         do_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].ovf,
               $sformatf("d1_v%0d", i));
         do_op(1'b1, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].ovf,
               $sformatf("d4_v%0d", i));
      end

      // start held through the run with operands changing, then back-to-back on the done cycle
      sel4   = 1'b0;
      a      = 8'h35;
      b      = 8'h12;
      bin    = 1'b0;
      start1 = 1'b1;
      @(posedge clk); #1;
      a = 8'hFF;
      b = 8'h00;
      wait_done(lat, seen, steady);
      check("hold_seen",    32'(seen), 32'd1);
      check("hold_latency", 32'(lat), 32'd8);
      check("hold_diff",    32'(diff1), 32'h23);
      check("hold_bout",    32'(bout1), 32'd0);
      @(posedge clk); #1;
      start1 = 1'b0;
      check("b2b_busy", 32'(busy1), 32'd1);
      check("b2b_done_low", 32'(done1), 32'd0);
      wait_done(lat, seen, steady);
      check("b2b_seen",    32'(seen), 32'd1);
      check("b2b_latency", 32'(lat), 32'd8);
      check("b2b_steady",  32'(steady), 32'd1);
      check("b2b_diff",    32'(diff1), 32'hFF);
      check("b2b_bout",    32'(bout1), 32'd0);

      // reset four cycles into an operation aborts it
      @(posedge clk); #1;
      a      = 8'h35;
      b      = 8'h12;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", 32'(busy1), 32'd0);
      check("abort_done", 32'(done1), 32'd0);
      check("abort_diff", 32'(diff1), 32'd0);
      check("abort_bout", 32'(bout1), 32'd0);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done1 === 1'b1) seen = 1'b1;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      do_op(1'b0, 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, "after_abort");

      // random operations against the a-b-bin reference
      for (int k = 0; k < 1200; k++) begin
         ra   = 8'($urandom_range(0, 255));
         rb   = 8'($urandom_range(0, 255));
         rbin = 1'($urandom_range(0, 1));
         ref9 = {1'b0, ra} - {1'b0, rb} - {8'h00, rbin};
         rovf = (ra[7] != rb[7]) && (ref9[7] != ra[7]);
         do_op(k >= 1000, ra, rb, rbin, ref9[7:0], ref9[8], rovf, $sformatf("rnd%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
